rr_grant_arbiter: RTL

RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

---
 rtl/rr_grant_arbiter_pkg.sv | 21 ++
 rtl/rr_priority_select.sv | 21 ++
 rtl/rr_grant_arbiter.sv | 82 ++++++++
 3 files changed

// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
// Holds the FSM state encoding and the one-hot to index encoder.
package rr_grant_arbiter_pkg;

    localparam int MAX_REQ = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [4:0] oh2idx(input logic [MAX_REQ-1:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx |= 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first request bit at or above the
// one-hot pointer, wrapping from the top bit back to bit 0.
module rr_priority_select #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [NUM_REQ-1:0] ptr,
    output logic [NUM_REQ-1:0] winner
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] pick;

    // The borrow of (dbl - ptr) stops at the first set bit at/above ptr.
    always_comb begin
        dbl    = {request, request};
        pick   = dbl & ~(dbl - {{NUM_REQ{1'b0}}, ptr});
        winner = pick[NUM_REQ-1:0] | pick[2*NUM_REQ-1:NUM_REQ];
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered grant held until acknowledged.
// Back-to-back grants on ack; the acked winner drops to lowest priority.
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] request,
    input  logic               grant_ack,
    output logic               grant_valid,
    output logic [NUM_REQ-1:0] grant_one_hot,
    output logic [ID_W-1:0]    grant_id
);

    state_t               state, state_d;
    logic [NUM_REQ-1:0]   ptr, ptr_d;
    logic [NUM_REQ-1:0]   gnt_d, win, sel_ptr, rot;
    logic [2*NUM_REQ-1:0] rot_dbl;
    logic [MAX_REQ-1:0]   gnt_ext;
    logic [ID_W-1:0]      id_d;

    rr_priority_select #(
        .NUM_REQ(NUM_REQ)
    ) u_sel (
        .request(request),
        .ptr    (sel_ptr),
        .winner (win)
    );

    // In GRANT the selector already looks ahead with the post-ack pointer.
    always_comb begin
        rot_dbl = {grant_one_hot, grant_one_hot} << 1;
        rot     = rot_dbl[2*NUM_REQ-1:NUM_REQ];
        sel_ptr = (state == GRANT) ? rot : ptr;
        state_d = state;
        ptr_d   = ptr;
        gnt_d   = grant_one_hot;
        unique case (state)
            IDLE: begin
                if (|request) begin
                    state_d = GRANT;
                    gnt_d   = win;
                end
            end
            GRANT: begin
                if (grant_ack) begin
                    ptr_d = rot;
                    if (|request) begin
                        gnt_d = win;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: ;
        endcase
        gnt_ext                = '0;
        gnt_ext[NUM_REQ-1:0]   = gnt_d;
        id_d                   = ID_W'(oh2idx(gnt_ext));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            ptr           <= NUM_REQ'(1);
            grant_valid   <= 1'b0;
            grant_one_hot <= '0;
            grant_id      <= '0;
        end else begin
            state         <= state_d;
            ptr           <= ptr_d;
            grant_valid   <= (state_d == GRANT);
            grant_one_hot <= gnt_d;
            grant_id      <= id_d;
        end
    end

endmodule
